// File: rtl/reg_scoreboard.sv
// In-order register-writeback scoreboard: queues model writes and compares them with DUT commits.
// Optional feature: define REG_SB_REG0_FILTER_EN to discard address-0 writes on both streams.
module reg_scoreboard #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                       Clock,
    input  logic                       nReset,
    input  logic                       ExpValid,
    input  logic [ADDR_W-1:0]          ExpAddr,
    input  logic [DATA_W-1:0]          ExpData,
    output logic                       ExpReady,
    input  logic                       ActValid,
    input  logic [ADDR_W-1:0]          ActAddr,
    input  logic [DATA_W-1:0]          ActData,
    output logic                       Mismatch,
    output logic [ADDR_W-1:0]          MisAddr,
    output logic [DATA_W-1:0]          MisExp,
    output logic [DATA_W-1:0]          MisAct,
    output logic                       Overflow,
    output logic                       Unexpected,
    output logic                       Timeout,
    output logic                       Fault,
    output logic [$clog2(DEPTH+1)-1:0] Level,
    output logic [CNT_W-1:0]           MatchCount,
    output logic [CNT_W-1:0]           ErrCount
);

    localparam int unsigned LW  = $clog2(DEPTH + 1);
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned AGW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StEmpty, StActive, StFault} state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PW-1:0]     wptr_q, rptr_q;
    logic [LW-1:0]     level_q, level_d;
    logic [AGW-1:0]    age_q, age_d;
    logic              exp_v, act_v;
    logic              full, empty, in_fault;
    logic              bypass, push, pop;
    logic              ovf_set, unx_set, tmo_set;
    logic              overflow_q, unexpected_q, timeout_q;

    logic              cmp_v_q;
    logic [ADDR_W-1:0] cmp_ea_q, cmp_aa_q;
    logic [DATA_W-1:0] cmp_ed_q, cmp_ad_q;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    logic              mismatch_q;
    logic [ADDR_W-1:0] mis_addr_q;
    logic [DATA_W-1:0] mis_exp_q, mis_act_q;
    logic [CNT_W-1:0]  match_cnt_q, err_cnt_q;

`ifdef REG_SB_REG0_FILTER_EN
    // Register 0 is hardwired to zero, so its writes carry no information.
    assign exp_v = ExpValid && (ExpAddr != '0);
    assign act_v = ActValid && (ActAddr != '0);
`else
    assign exp_v = ExpValid;
    assign act_v = ActValid;
`endif

    assign head_addr = addr_mem[rptr_q];
    assign head_data = data_mem[rptr_q];

    always_comb begin
        full     = (level_q == LW'(DEPTH));
        empty    = (level_q == '0);
        in_fault = (state_q == StFault);
        bypass   = !in_fault && empty && exp_v && act_v;
        push     = !in_fault && exp_v && !full && !bypass;
        pop      = !in_fault && act_v && !empty;
        ovf_set  = !in_fault && exp_v && full;
        unx_set  = !in_fault && act_v && empty && !exp_v;
        tmo_set  = !in_fault && !empty && !pop && (age_q == AGW'(TIMEOUT - 1));

        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        age_d = age_q;
        if (!in_fault) begin
            if (empty || pop) begin
                age_d = '0;
            end else if (age_q != AGW'(TIMEOUT)) begin
                age_d = age_q + AGW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (in_fault || ovf_set || unx_set || tmo_set) begin
            state_d = StFault;
        end else if (level_d == '0) begin
            state_d = StEmpty;
        end else begin
            state_d = StActive;
        end
    end

    always_ff @(posedge Clock) begin
        if (!nReset && push) begin
            addr_mem[wptr_q] <= ExpAddr;
            data_mem[wptr_q] <= ExpData;
        end
    end

    always_ff @(posedge Clock) begin
        if (nReset) begin
            state_q      <= StEmpty;
            wptr_q       <= '0;
            rptr_q       <= '0;
            level_q      <= '0;
            age_q        <= '0;
            overflow_q   <= 1'b0;
            unexpected_q <= 1'b0;
            timeout_q    <= 1'b0;
            cmp_v_q      <= 1'b0;
            cmp_ea_q     <= '0;
            cmp_aa_q     <= '0;
            cmp_ed_q     <= '0;
            cmp_ad_q     <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            age_q   <= age_d;
            if (push) begin
                wptr_q <= (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1);
            end
            if (ovf_set) overflow_q <= 1'b1;
            if (unx_set) unexpected_q <= 1'b1;
            if (tmo_set) timeout_q <= 1'b1;
            // First compare stage: capture both sides of the pair being checked.
            cmp_v_q  <= pop || bypass;
            cmp_ea_q <= bypass ? ExpAddr : head_addr;
            cmp_ed_q <= bypass ? ExpData : head_data;
            cmp_aa_q <= ActAddr;
            cmp_ad_q <= ActData;
        end
    end

    // Second compare stage; a pair accepted just before FAULT still completes.
    always_ff @(posedge Clock) begin
        if (nReset) begin
            mismatch_q  <= 1'b0;
            mis_addr_q  <= '0;
            mis_exp_q   <= '0;
            mis_act_q   <= '0;
            match_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            mismatch_q <= 1'b0;
            if (cmp_v_q) begin
                if ((cmp_ea_q == cmp_aa_q) && (cmp_ed_q == cmp_ad_q)) begin
                    if (match_cnt_q != '1) match_cnt_q <= match_cnt_q + CNT_W'(1);
                end else begin
                    mismatch_q <= 1'b1;
                    mis_addr_q <= cmp_ea_q;
                    mis_exp_q  <= cmp_ed_q;
                    mis_act_q  <= cmp_ad_q;
                    if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign ExpReady   = !full;
    assign Mismatch   = mismatch_q;
    assign MisAddr    = mis_addr_q;
    assign MisExp     = mis_exp_q;
    assign MisAct     = mis_act_q;
    assign Overflow   = overflow_q;
    assign Unexpected = unexpected_q;
    assign Timeout    = timeout_q;
    assign Fault      = (state_q == StFault);
    assign Level      = level_q;
    assign MatchCount = match_cnt_q;
    assign ErrCount   = err_cnt_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: a small reference model queues expected compare results
// that are checked when the DUT's registered outputs become valid.
module tb_reg_scoreboard;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int TMO   = 64;
    localparam int CW    = 16;

    logic          Clock = 1'b0;
    logic          nReset = 1'b1;
    logic          ExpValid = 1'b0;
    logic [AW-1:0] ExpAddr = '0;
    logic [DW-1:0] ExpData = '0;
    logic          ExpReady;
    logic          ActValid = 1'b0;
    logic [AW-1:0] ActAddr = '0;
    logic [DW-1:0] ActData = '0;
    logic          Mismatch;
    logic [AW-1:0] MisAddr;
    logic [DW-1:0] MisExp, MisAct;
    logic          Overflow, Unexpected, Timeout, Fault;
    logic [$clog2(DEPTH+1)-1:0] Level;
    logic [CW-1:0] MatchCount, ErrCount;

    always #5 Clock = ~Clock;

    reg_scoreboard #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .TIMEOUT(TMO),
        .CNT_W  (CW)
    ) dut (
        .Clock     (Clock),
        .nReset    (nReset),
        .ExpValid  (ExpValid),
        .ExpAddr   (ExpAddr),
        .ExpData   (ExpData),
        .ExpReady  (ExpReady),
        .ActValid  (ActValid),
        .ActAddr   (ActAddr),
        .ActData   (ActData),
        .Mismatch  (Mismatch),
        .MisAddr   (MisAddr),
        .MisExp    (MisExp),
        .MisAct    (MisAct),
        .Overflow  (Overflow),
        .Unexpected(Unexpected),
        .Timeout   (Timeout),
        .Fault     (Fault),
        .Level     (Level),
        .MatchCount(MatchCount),
        .ErrCount  (ErrCount)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    typedef struct {
        logic          mis;
        logic [AW-1:0] a;
        logic [DW-1:0] e;
        logic [DW-1:0] x;
        int            due;
    } res_t;

    ent_t fifo_m[$];
    res_t res_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   match_m = 0;
    int   err_m = 0;
    logic fault_m = 1'b0;
    logic ovf_m = 1'b0;
    logic unx_m = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and check any compare result due after it.
    task automatic tick();
        res_t r;
        @(posedge Clock);
        cyc++;
        #1;
        if (res_q.size() > 0 && res_q[0].due == cyc) begin
            r = res_q.pop_front();
            if (r.mis) err_m++;
            else match_m++;
            chk("mismatch", Mismatch, r.mis);
            if (r.mis) begin
                chk("mis_addr", MisAddr, r.a);
                chk("mis_exp", MisExp, r.e);
                chk("mis_act", MisAct, r.x);
            end
            chk("match_count", MatchCount, match_m);
            chk("err_count", ErrCount, err_m);
        end else begin
            chk("mismatch_idle", Mismatch, 1'b0);
        end
    endtask

    task automatic drive(input logic ev, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                         input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad);
        logic fev, fav, was_empty, was_full;
        res_t r;
        ent_t e;
        fev = ev;
        fav = av;
`ifdef REG_SB_REG0_FILTER_EN
        if (ea == '0) fev = 1'b0;
        if (aa == '0) fav = 1'b0;
`endif
        was_empty = (fifo_m.size() == 0);
        was_full  = (fifo_m.size() == DEPTH);
        if (!fault_m) begin
            if (was_empty && fev && fav) begin
                r.mis = !((ea == aa) && (ed == ad));
                r.a = ea; r.e = ed; r.x = ad; r.due = cyc + 2;
                res_q.push_back(r);
            end else begin
                if (fav && !was_empty) begin
                    e = fifo_m.pop_front();
                    r.mis = !((e.a == aa) && (e.d == ad));
                    r.a = e.a; r.e = e.d; r.x = ad; r.due = cyc + 2;
                    res_q.push_back(r);
                end
                if (fev && was_full) begin
                    ovf_m = 1'b1;
                    fault_m = 1'b1;
                end else if (fev) begin
                    e.a = ea; e.d = ed;
                    fifo_m.push_back(e);
                end
                if (fav && was_empty) begin
                    unx_m = 1'b1;
                    fault_m = 1'b1;
                end
            end
        end
        ExpValid = ev; ExpAddr = ea; ExpData = ed;
        ActValid = av; ActAddr = aa; ActData = ad;
        tick();
        ExpValid = 1'b0;
        ActValid = 1'b0;
        chk("level", Level, fifo_m.size());
        chk("fault", Fault, fault_m);
        chk("overflow", Overflow, ovf_m);
        chk("unexpected", Unexpected, unx_m);
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    // Valid inputs are held high through the reset edge; they must be ignored.
    task automatic do_reset();
        res_q.delete();
        fifo_m.delete();
        match_m = 0; err_m = 0;
        fault_m = 1'b0; ovf_m = 1'b0; unx_m = 1'b0;
        nReset = 1'b1;
        ExpValid = 1'b1; ExpAddr = 5'd1; ExpData = 32'h1;
        ActValid = 1'b1; ActAddr = 5'd2; ActData = 32'h2;
        tick();
        nReset = 1'b0;
        ExpValid = 1'b0;
        ActValid = 1'b0;
        chk("rst_level", Level, 0);
        chk("rst_ready", ExpReady, 1'b1);
        chk("rst_fault", Fault, 1'b0);
        chk("rst_overflow", Overflow, 1'b0);
        chk("rst_unexpected", Unexpected, 1'b0);
        chk("rst_timeout", Timeout, 1'b0);
        chk("rst_mis_addr", MisAddr, 0);
        chk("rst_mis_exp", MisExp, 0);
        chk("rst_mis_act", MisAct, 0);
        chk("rst_match", MatchCount, 0);
        chk("rst_err", ErrCount, 0);
    endtask

    initial begin
        tick();
        do_reset();

        // Two in-order matches committed two cycles after the pushes.
        drive(1'b1, 5'd3, 32'h11, 1'b0, '0, '0);
        drive(1'b1, 5'd4, 32'h22, 1'b0, '0, '0);
        idle();
        idle();
        drive(1'b0, '0, '0, 1'b1, 5'd3, 32'h11);
        drive(1'b0, '0, '0, 1'b1, 5'd4, 32'h22);
        idle();
        idle();
        chk("pair_match", MatchCount, 2);
        chk("pair_err", ErrCount, 0);

        // Data mismatch.
        drive(1'b1, 5'd7, 32'hDEADBEEF, 1'b0, '0, '0);
        idle();
        drive(1'b0, '0, '0, 1'b1, 5'd7, 32'hDEADBEEE);
        idle();
        idle();
        chk("mis_err_total", ErrCount, 1);
        chk("mis_level", Level, 0);

        // Fill, then overflow with a same-cycle pop.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, AW'(i + 1), 32'h100 + DW'(i), 1'b0, '0, '0);
        end
        chk("full_ready", ExpReady, 1'b0);
        chk("full_level", Level, DEPTH);
        drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd1, 32'h100);
        idle();
        drive(1'b0, '0, '0, 1'b1, 5'd2, 32'h101);
        drive(1'b0, '0, '0, 1'b1, 5'd3, 32'hBAD);
        idle();
        idle();
        chk("frozen_match", MatchCount, 3);
        chk("frozen_err", ErrCount, 1);
        chk("frozen_level", Level, DEPTH - 1);

        // Bypass compare, then an unexpected commit.
        do_reset();
        drive(1'b1, 5'd5, 32'h5, 1'b1, 5'd5, 32'h5);
        idle();
        chk("bypass_match", MatchCount, 1);
        drive(1'b0, '0, '0, 1'b1, 5'd6, 32'h6);
        idle();

        // Head entry ages out exactly TMO edges after its push.
        do_reset();
        drive(1'b1, 5'd9, 32'h9, 1'b0, '0, '0);
        repeat (TMO - 1) tick();
        chk("tmo_early", Timeout, 1'b0);
        tick();
        chk("tmo_hit", Timeout, 1'b1);
        chk("tmo_fault", Fault, 1'b1);
        chk("tmo_level", Level, 1);

        // Reset from FAULT, then an address-0 write pair.
        do_reset();
        drive(1'b1, 5'd0, 32'h1, 1'b0, '0, '0);
        idle();
        drive(1'b0, '0, '0, 1'b1, 5'd0, 32'h2);
        idle();
        idle();
`ifdef REG_SB_REG0_FILTER_EN
        chk("reg0_err", ErrCount, 0);
`else
        chk("reg0_err", ErrCount, 1);
`endif
        chk("reg0_match", MatchCount, 0);
        chk("reg0_level", Level, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
